seg7_scan_driver: RTL and testbench

Multiplexed driver for a multi-digit common-bus 7-segment display. It sits downstream of the per-digit counter/decoder stage. It accepts a packed BCD word through a load strobe, holds it in a shadow register, and commits it tear-free at frame boundaries. It time-multiplexes one digit at a time onto the shared segment bus, with a ghosting guard, leading-zero blanking and per-digit decimal points.

---
 rtl/seg7_pkg.sv | 38 +++
 rtl/scan_tick_gen.sv | 34 +++
 rtl/seg7_scan_driver.sv | 147 ++++++++++++++
 tb/tb_seg7_scan_driver.sv | 137 +++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// seg7_pkg: 7-segment glyph encoding shared by the display driver and the
// upstream per-digit counter/decoder stage. Segment order is {a,b,c,d,e,f,g,dp}
// with a in the MSB, active-high.
package seg7_pkg;

   localparam logic [7:0] SEG_0     = 8'b11111100;
   localparam logic [7:0] SEG_1     = 8'b01100000;
   localparam logic [7:0] SEG_2     = 8'b11011010;
   localparam logic [7:0] SEG_3     = 8'b11110010;
   localparam logic [7:0] SEG_4     = 8'b01100110;
   localparam logic [7:0] SEG_5     = 8'b10110110;
   localparam logic [7:0] SEG_6     = 8'b10111110;
   localparam logic [7:0] SEG_7     = 8'b11100000;
   localparam logic [7:0] SEG_8     = 8'b11111110;
   localparam logic [7:0] SEG_9     = 8'b11100110;
   localparam logic [7:0] SEG_BLANK = 8'b00000000;

   // Segments a..g for one BCD nibble; anything above 9 shows as blank so a
   // corrupted digit is visibly wrong rather than mistaken for a number.
   function automatic logic [6:0] bcd_to_seg(input logic [3:0] nibble);
      logic [6:0] g;
      case (nibble)
         4'd0:    g = SEG_0[7:1];
         4'd1:    g = SEG_1[7:1];
         4'd2:    g = SEG_2[7:1];
         4'd3:    g = SEG_3[7:1];
         4'd4:    g = SEG_4[7:1];
         4'd5:    g = SEG_5[7:1];
         4'd6:    g = SEG_6[7:1];
         4'd7:    g = SEG_7[7:1];
         4'd8:    g = SEG_8[7:1];
         4'd9:    g = SEG_9[7:1];
         default: g = SEG_BLANK[7:1];
      endcase
      return g;
   endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// scan_tick_gen: free-running prescaler that divides clk into digit slots.
// tick_o marks the last cycle of a slot; phase_o is the position within the
// slot and drives the ghosting-guard window in the display driver.
module scan_tick_gen #(
   parameter int DIV   = 1000,
   parameter int CNT_W = (DIV > 1) ? $clog2(DIV) : 1
) (
   input  logic             clk,
   input  logic             rst,
   output logic             tick_o,
   output logic [CNT_W-1:0] phase_o
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   assign tick_o  = (cnt_q == CNT_W'(DIV - 1));
   assign phase_o = cnt_q;

   // Next count: wrap to zero at the end of each slot.
   always_comb begin
      cnt_d = tick_o ? '0 : cnt_q + CNT_W'(1);
   end

   // Prescaler state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed driver for a common-bus multi-digit
// 7-segment display. New values land in a shadow register and are moved to
// the display register only at a frame wrap, so a frame never mixes old and
// new digits. Outputs are registered and trail the slot state by one cycle.
module seg7_scan_driver
   import seg7_pkg::*;
#(
   parameter int NUM_DIGITS = 8,
   parameter int SCAN_DIV   = 1000,
   parameter int BLANK_CYC  = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] value_bcd,
   input  logic [NUM_DIGITS-1:0]   dp_mask,
   input  logic                    lz_blank,
   output logic [NUM_DIGITS-1:0]   digit,
   output logic [7:0]              seg,
   output logic                    pending,
   output logic                    frame_done
);

   localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int IDX_W = $clog2(NUM_DIGITS);

   logic                    slot_tick;
   logic [CNT_W-1:0]        phase;
   logic                    frame_wrap;

   logic [IDX_W-1:0]        idx_q,        idx_d;
   logic [4*NUM_DIGITS-1:0] shadow_val_q, shadow_val_d;
   logic [NUM_DIGITS-1:0]   shadow_dp_q,  shadow_dp_d;
   logic                    pending_q,    pending_d;
   logic [4*NUM_DIGITS-1:0] disp_val_q,   disp_val_d;
   logic [NUM_DIGITS-1:0]   disp_dp_q,    disp_dp_d;
   logic [NUM_DIGITS-1:0]   digit_q,      digit_d;
   logic [7:0]              seg_q,        seg_d;
   logic                    frame_done_q;

   logic [NUM_DIGITS-1:0]   lead_zero;
   logic [3:0]              cur_nib;
   logic                    cur_dp;
   logic                    lz_hide;
   logic [6:0]              glyph;

   scan_tick_gen #(
      .DIV   (SCAN_DIV),
      .CNT_W (CNT_W)
   ) u_tick (
      .clk     (clk),
      .rst     (rst),
      .tick_o  (slot_tick),
      .phase_o (phase)
   );

   // The last slot of the last digit closes the frame.
   assign frame_wrap = slot_tick && (idx_q == IDX_W'(NUM_DIGITS - 1));

   // Slot index advance and the shadow/display handoff. A load landing on the
   // wrap cycle bypasses the shadow so it is not held back a whole frame.
   always_comb begin
      idx_d        = idx_q;
      shadow_val_d = shadow_val_q;
      shadow_dp_d  = shadow_dp_q;
      pending_d    = pending_q;
      disp_val_d   = disp_val_q;
      disp_dp_d    = disp_dp_q;

      if (slot_tick) begin
         idx_d = frame_wrap ? '0 : idx_q + IDX_W'(1);
      end

      if (load) begin
         shadow_val_d = value_bcd;
         shadow_dp_d  = dp_mask;
      end

      if (frame_wrap) begin
         pending_d = 1'b0;
         if (load) begin
            disp_val_d = value_bcd;
            disp_dp_d  = dp_mask;
         end else if (pending_q) begin
            disp_val_d = shadow_val_q;
            disp_dp_d  = shadow_dp_q;
         end
      end else if (load) begin
         pending_d = 1'b1;
      end
   end

   // lead_zero[i] is set when every nibble from the top digit down to i is 0.
   always_comb begin
      lead_zero = '0;
      lead_zero[NUM_DIGITS-1] = (disp_val_q[4*(NUM_DIGITS-1) +: 4] == 4'd0);
      for (int i = NUM_DIGITS - 2; i >= 0; i--) begin
         lead_zero[i] = lead_zero[i+1] && (disp_val_q[4*i +: 4] == 4'd0);
      end
   end

   // Segment pattern for the current slot. The dp bit ignores leading-zero
   // blanking; only the ghosting guard at slot start silences it.
   always_comb begin
      cur_nib = disp_val_q[{idx_q, 2'b00} +: 4];
      cur_dp  = disp_dp_q[idx_q];
      lz_hide = lz_blank && (idx_q != '0) && lead_zero[idx_q];
      glyph   = lz_hide ? 7'b0 : bcd_to_seg(cur_nib);
      digit_d = NUM_DIGITS'(1) << idx_q;
      if (phase < CNT_W'(BLANK_CYC)) begin
         seg_d = SEG_BLANK;
      end else begin
         seg_d = {glyph, cur_dp};
      end
   end

   // All state; reset discards any uncommitted shadow contents.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx_q        <= '0;
         shadow_val_q <= '0;
         shadow_dp_q  <= '0;
         pending_q    <= 1'b0;
         disp_val_q   <= '0;
         disp_dp_q    <= '0;
         digit_q      <= '0;
         seg_q        <= '0;
         frame_done_q <= 1'b0;
      end else begin
         idx_q        <= idx_d;
         shadow_val_q <= shadow_val_d;
         shadow_dp_q  <= shadow_dp_d;
         pending_q    <= pending_d;
         disp_val_q   <= disp_val_d;
         disp_dp_q    <= disp_dp_d;
         digit_q      <= digit_d;
         seg_q        <= seg_d;
         frame_done_q <= frame_wrap;
      end
   end

   assign digit      = digit_q;
   assign seg        = seg_q;
   assign pending    = pending_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: directed bench, 4 digits, 4-cycle slots, 1 guard cycle.
module tb_seg7_scan_driver;

   logic        clk = 1'b0;
   logic        rst;
   logic        load;
   logic [15:0] value_bcd;
   logic [3:0]  dp_mask;
   logic        lz_blank;
   logic [3:0]  digit;
   logic [7:0]  seg;
   logic        pending;
   logic        frame_done;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   seg7_scan_driver #(
      .NUM_DIGITS (4),
      .SCAN_DIV   (4),
      .BLANK_CYC  (1)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .load       (load),
      .value_bcd  (value_bcd),
      .dp_mask    (dp_mask),
      .lz_blank   (lz_blank),
      .digit      (digit),
      .seg        (seg),
      .pending    (pending),
      .frame_done (frame_done)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   // One 16-cycle frame starting right after a frame boundary. g[k] is the
   // pattern expected on digit k outside its guard cycle. Up to two loads may
   // be issued at frame cycles l1/l2 (-1 = none).
   task automatic run_frame(input string tag, input logic [3:0][7:0] g,
                            input int l1, input logic [15:0] v1, input logic [3:0] d1,
                            input int l2, input logic [15:0] v2, input logic [3:0] d2);
      logic [7:0] exp_seg;
      logic [3:0] exp_dig;
      bit         early_ld;
      early_ld = (l1 >= 0 && l1 < 15) || (l2 >= 0 && l2 < 15);
      for (int j = 0; j < 16; j++) begin
         load = 1'b0;
         if (j == l1) begin
            load = 1'b1; value_bcd = v1; dp_mask = d1;
         end else if (j == l2) begin
            load = 1'b1; value_bcd = v2; dp_mask = d2;
         end
         @(posedge clk);
         #1;
         load    = 1'b0;
         exp_dig = 4'b0001 << (j / 4);
         exp_seg = ((j % 4) == 0) ? 8'h00 : g[j/4];
         check($sformatf("%s_j%0d_digit", tag, j), 32'(digit), 32'(exp_dig));
         check($sformatf("%s_j%0d_seg", tag, j), 32'(seg), 32'(exp_seg));
         check($sformatf("%s_j%0d_fdone", tag, j), 32'(frame_done), (j == 15) ? 32'd1 : 32'd0);
         if ((j == l1 || j == l2) && j < 15)
            check($sformatf("%s_j%0d_pend_ld", tag, j), 32'(pending), 32'd1);
         if (j == 14)
            check($sformatf("%s_pend_pre", tag), 32'(pending), early_ld ? 32'd1 : 32'd0);
         if (j == 15)
            check($sformatf("%s_pend_wrap", tag), 32'(pending), 32'd0);
      end
   endtask

   initial begin
      rst       = 1'b1;
      load      = 1'b0;
      value_bcd = 16'h0000;
      dp_mask   = 4'b0000;
      lz_blank  = 1'b0;

      @(posedge clk);
      @(posedge clk);
      #1;
      check("rst_digit", 32'(digit), 32'd0);
      check("rst_seg", 32'(seg), 32'd0);
      check("rst_pend", 32'(pending), 32'd0);
      check("rst_fdone", 32'(frame_done), 32'd0);
      rst = 1'b0;

      // Display still zero in frame 0; 0x1234 is shadowed and committed at wrap.
      run_frame("f0", {8'hFC, 8'hFC, 8'hFC, 8'hFC}, 0, 16'h1234, 4'b0000, -1, 16'h0, 4'h0);
      lz_blank = 1'b1;
      run_frame("f1", {8'h60, 8'hDA, 8'hF2, 8'h66}, 3, 16'h0070, 4'b0000, -1, 16'h0, 4'h0);
      run_frame("f2", {8'h00, 8'h00, 8'hE0, 8'hFC}, 5, 16'h0000, 4'b0000, -1, 16'h0, 4'h0);
      run_frame("f3", {8'h00, 8'h00, 8'h00, 8'hFC}, 2, 16'h1111, 4'b0000, 9, 16'h2222, 4'b0000);
      // Load exactly on the wrap cycle goes straight to the display.
      run_frame("f4", {8'hDA, 8'hDA, 8'hDA, 8'hDA}, 15, 16'h5555, 4'b0000, -1, 16'h0, 4'h0);
      run_frame("f5", {8'hB6, 8'hB6, 8'hB6, 8'hB6}, 0, 16'h00A9, 4'b0010, -1, 16'h0, 4'h0);
      run_frame("f6", {8'h00, 8'h00, 8'h01, 8'hE6}, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);

      // Asynchronous reset mid-slot with data pending.
      load = 1'b1; value_bcd = 16'h8888; dp_mask = 4'b1111;
      @(posedge clk);
      #1;
      load = 1'b0;
      @(posedge clk);
      #1;
      check("pre_rst_pend", 32'(pending), 32'd1);
      check("pre_rst_digit_nz", 32'(digit != 4'd0), 32'd1);
      #1;
      rst = 1'b1;
      #1;
      check("arst_digit", 32'(digit), 32'd0);
      check("arst_seg", 32'(seg), 32'd0);
      check("arst_pend", 32'(pending), 32'd0);
      check("arst_fdone", 32'(frame_done), 32'd0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      lz_blank = 1'b0;
      check("rel_pend", 32'(pending), 32'd0);

      // No stale commit: zeros in both frames after release.
      run_frame("r0", {8'hFC, 8'hFC, 8'hFC, 8'hFC}, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);
      run_frame("r1", {8'hFC, 8'hFC, 8'hFC, 8'hFC}, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
